mor1kx_bpred_gshare: RTL and testbench

Global-history (gshare) conditional-branch predictor for the mor1kx pipeline. In decode it combinationally predicts the flag for an `l.bf`/`l.bnf`, using a table of 2-bit saturating counters indexed by global history XOR branch PC. When the branch resolves in execute, it updates the counter used for that prediction and shifts the actual outcome into the history. It is selected by the branch-prediction wrapper when `FEATURE_BRANCH_PREDICTOR` is `"GSHARE"`.

---
 rtl/mor1kx_bpred_pkg.sv | 19 +
 rtl/mor1kx_bpred_sat_ctr2.sv | 21 ++
 rtl/mor1kx_bpred_gshare.sv | 81 ++++++++
 tb/tb_mor1kx_bpred_gshare.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_bpred_pkg.sv
// Shared definitions for the mor1kx conditional-branch predictors:
// 2-bit counter encoding and the resolved-outcome derivation.
package mor1kx_bpred_pkg;

    typedef logic [1:0] bpred_ctr_t;

    localparam bpred_ctr_t STRONG_NT = 2'd0;
    localparam bpred_ctr_t WEAK_NT   = 2'd1;
    localparam bpred_ctr_t WEAK_T    = 2'd2;
    localparam bpred_ctr_t STRONG_T  = 2'd3;

    // A resolving l.bf is taken on flag=1, an l.bnf on flag=0.
    function automatic logic bpred_taken(input logic op_bf,
                                         input logic op_bnf,
                                         input logic flag);
        return (op_bf & flag) | (op_bnf & ~flag);
    endfunction

endpackage

// File: rtl/mor1kx_bpred_sat_ctr2.sv
// Combinational next-state of a 2-bit saturating branch counter.
module mor1kx_bpred_sat_ctr2
    import mor1kx_bpred_pkg::*;
(
    input  bpred_ctr_t ctr_i,
    input  logic       taken_i,
    output bpred_ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != STRONG_T)
                ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != STRONG_NT)
                ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/mor1kx_bpred_gshare.sv
// Gshare predictor: 2-bit counters indexed by global history XOR branch PC,
// predicted combinationally in decode, trained when the branch resolves.
module mor1kx_bpred_gshare
    import mor1kx_bpred_pkg::*;
#(
    parameter int GSHARE_BITS_NUM      = 10,
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
    output logic                            predicted_flag_o,

    input  logic                            execute_op_bf_i,
    input  logic                            execute_op_bnf_i,
    input  logic                            flag_i,
    input  logic                            prev_op_brcond_i,
    input  logic                            padv_decode_i,
    input  logic                            branch_mispredict_i
);

    localparam int TABLE_SIZE = 1 << GSHARE_BITS_NUM;

    logic [GSHARE_BITS_NUM-1:0] hist;
    logic [GSHARE_BITS_NUM-1:0] prev_idx;
    logic [GSHARE_BITS_NUM-1:0] idx;
    bpred_ctr_t                 ctr [TABLE_SIZE];
    bpred_ctr_t                 ctr_rd;
    bpred_ctr_t                 ctr_nxt;
    logic                       taken;
    logic                       capture_en;
    logic                       update_en;

    // Word-aligned PC bits hash with history; low two PC bits are always 0.
    assign idx    = hist ^ brn_pc_i[GSHARE_BITS_NUM+1:2];
    assign ctr_rd = ctr[idx];

    assign predicted_flag_o = (op_bf_i & ctr_rd[1]) | (op_bnf_i & ~ctr_rd[1]);

    assign capture_en = padv_decode_i & (op_bf_i | op_bnf_i);
    assign update_en  = prev_op_brcond_i & padv_decode_i;
    assign taken      = bpred_taken(execute_op_bf_i, execute_op_bnf_i, flag_i);

    mor1kx_bpred_sat_ctr2 u_sat_ctr2 (
        .ctr_i   (ctr[prev_idx]),
        .taken_i (taken),
        .ctr_o   (ctr_nxt)
    );

    // prev_idx captures idx built from the pre-update history, so a
    // same-cycle capture and update stay consistent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= '0;
            prev_idx <= '0;
        end else begin
            if (capture_en)
                prev_idx <= idx;
            if (update_en)
                hist <= {hist[GSHARE_BITS_NUM-2:0], taken};
        end
    end

    // Register array rather than RAM: it needs reset and a combinational read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TABLE_SIZE; i++)
                ctr[i] <= WEAK_T;
        end else if (update_en) begin
            ctr[prev_idx] <= ctr_nxt;
        end
    end

    // Mispredict is informational; upper/lower PC bits are not hashed.
    logic unused_sig;
    assign unused_sig = ^{branch_mispredict_i, brn_pc_i};

endmodule

// File: tb/tb_mor1kx_bpred_gshare.sv
// Directed bench for mor1kx_bpred_gshare with a behavioural gshare model.
module tb_mor1kx_bpred_gshare;

    localparam int MASK = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        op_bf_i = 1'b0;
    logic        op_bnf_i = 1'b0;
    logic [31:0] brn_pc_i = '0;
    logic        predicted_flag_o;
    logic        execute_op_bf_i = 1'b0;
    logic        execute_op_bnf_i = 1'b0;
    logic        flag_i = 1'b0;
    logic        prev_op_brcond_i = 1'b0;
    logic        padv_decode_i = 1'b0;
    logic        branch_mispredict_i = 1'b0;

    always #5 clk = ~clk;

    mor1kx_bpred_gshare dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .op_bf_i             (op_bf_i),
        .op_bnf_i            (op_bnf_i),
        .brn_pc_i            (brn_pc_i),
        .predicted_flag_o    (predicted_flag_o),
        .execute_op_bf_i     (execute_op_bf_i),
        .execute_op_bnf_i    (execute_op_bnf_i),
        .flag_i              (flag_i),
        .prev_op_brcond_i    (prev_op_brcond_i),
        .padv_decode_i       (padv_decode_i),
        .branch_mispredict_i (branch_mispredict_i)
    );

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Model state: plain integers for counters (0..3), history and last index.
    int mctr [1024];
    int mhist;
    int mprev;
    int m_nprev;
    int m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mctr[i] = 2;
            mhist = 0;
            mprev = 0;
        end else begin
            m_nprev = mprev;
            if (padv_decode_i && (op_bf_i || op_bnf_i))
                m_nprev = (mhist ^ int'(brn_pc_i[11:2])) & MASK;
            if (prev_op_brcond_i && padv_decode_i) begin
                m_t = ((execute_op_bf_i && flag_i) || (execute_op_bnf_i && !flag_i)) ? 1 : 0;
                if (m_t == 1) mctr[mprev] = (mctr[mprev] >= 3) ? 3 : mctr[mprev] + 1;
                else          mctr[mprev] = (mctr[mprev] <= 0) ? 0 : mctr[mprev] - 1;
                mhist = ((mhist * 2) + m_t) & MASK;
            end
            mprev = m_nprev;
        end
    end

    function automatic logic model_pred();
        int i;
        i = (mhist ^ int'(brn_pc_i[11:2])) & MASK;
        return (op_bf_i && mctr[i] >= 2) || (op_bnf_i && mctr[i] < 2);
    endfunction

    function automatic logic [31:0] pc_for(int idx);
        return 32'(((idx ^ mhist) & MASK) * 4);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en)
            chk("pred_model", {31'd0, predicted_flag_o}, {31'd0, model_pred()});
    end

    task automatic tick();
        @(posedge clk);
        #1;
        branch_mispredict_i = ~branch_mispredict_i;
    endtask

    task automatic idle();
        op_bf_i = 0; op_bnf_i = 0; padv_decode_i = 0; prev_op_brcond_i = 0;
        execute_op_bf_i = 0; execute_op_bnf_i = 0; flag_i = 0;
    endtask

    task automatic issue(logic [31:0] pc, bit bnf);
        idle();
        brn_pc_i = pc; op_bf_i = !bnf; op_bnf_i = bnf; padv_decode_i = 1;
        tick();
        idle();
    endtask

    task automatic resolve(bit flag, bit adv);
        idle();
        prev_op_brcond_i = 1; execute_op_bf_i = 1; flag_i = flag; padv_decode_i = adv;
        tick();
        idle();
    endtask

    task automatic pred_at(string nm, logic [31:0] pc, bit bnf, bit exp);
        idle();
        brn_pc_i = pc; op_bf_i = !bnf; op_bnf_i = bnf;
        #1;
        chk(nm, {31'd0, predicted_flag_o}, {31'd0, exp});
        tick();
        idle();
    endtask

    int h0;

    initial begin
        #3 rst_n = 0;
        check_en = 1;
        @(posedge clk); #1;
        pred_at("rst_bf", 32'h123, 0, 1);
        pred_at("rst_bnf", 32'h2AA, 1, 0);
        rst_n = 1;
        tick();

        // Saturating up on index 0x40 (first PC is 0x100 with history 0)
        chk("pc_first", pc_for(32'h40), 32'h100);
        repeat (3) begin
            issue(pc_for(32'h40), 0);
            resolve(1, 1);
        end
        chk("hist_up", mhist, 7);
        chk("ctr40_up", mctr[32'h40], 3);
        pred_at("up_bf", pc_for(32'h40), 0, 1);
        pred_at("up_bnf", pc_for(32'h40), 1, 0);
        issue(pc_for(32'h40), 0);
        resolve(0, 1);
        chk("ctr40_nt", mctr[32'h40], 2);
        pred_at("up_nt_bf", pc_for(32'h40), 0, 1);

        // Saturating down on index 0x55
        issue(pc_for(32'h55), 0);
        resolve(0, 1);
        pred_at("dn1_bf", pc_for(32'h55), 0, 0);
        pred_at("dn1_bnf", pc_for(32'h55), 1, 1);
        repeat (2) begin
            issue(pc_for(32'h55), 0);
            resolve(0, 1);
        end
        chk("ctr55_dn", mctr[32'h55], 0);
        issue(pc_for(32'h55), 0);
        resolve(1, 1);
        pred_at("dn_up1_bf", pc_for(32'h55), 0, 0);
        issue(pc_for(32'h55), 0);
        resolve(1, 1);
        pred_at("dn_up2_bf", pc_for(32'h55), 0, 1);

        // Stalled resolve leaves history and counters alone
        issue(pc_for(32'h66), 0);
        h0 = mhist;
        repeat (3) resolve(0, 0);
        chk("stall_hist", mhist, h0);
        chk("stall_ctr", mctr[32'h66], 2);
        pred_at("stall_bf", pc_for(32'h66), 0, 1);
        resolve(0, 1);
        pred_at("after_stall_bf", pc_for(32'h66), 0, 0);

        // Aliasing: history 0x3FF with PC 0x200 hits entry 0x37F
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        repeat (10) begin
            issue(32'h0, 0);
            resolve(1, 1);
        end
        chk("alias_hist", mhist, 32'h3FF);
        issue(32'h200, 0);
        resolve(0, 1);
        chk("alias_ctr37f", mctr[32'h37F], 1);
        chk("alias_ctr080", mctr[32'h080], 2);
        pred_at("alias_37f_bf", pc_for(32'h37F), 0, 0);
        pred_at("alias_080_bf", pc_for(32'h080), 0, 1);

        // Reset asserted during a not-taken update
        issue(pc_for(32'h12), 0);
        idle();
        prev_op_brcond_i = 1; execute_op_bf_i = 1; flag_i = 0; padv_decode_i = 1;
        #2 rst_n = 0;
        @(posedge clk); #1;
        idle();
        tick();
        rst_n = 1;
        tick();
        chk("mid_rst_hist", mhist, 0);
        pred_at("mid_rst_37f", 32'h37F * 4, 0, 1);
        pred_at("mid_rst_12", 32'h12 * 4, 0, 1);
        pred_at("mid_rst_0_bnf", 32'h0, 1, 0);

        tick();
        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
